// File: rtl/management_bus_arbiter_pkg.sv
// management_bus_arbiter_pkg: arbiter state encoding, master ids and abort data
package management_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} arbState_e;
  localparam logic MASTER_JTAG = 1'b0;
  localparam logic MASTER_WB = 1'b1;
  localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/management_bus_arbiter_if.sv
// management_bus_arbiter_if: management bus request/response bundle (master drives the request)
interface management_bus_arbiter_if;
  logic writeEnable;
  logic readEnable;
  logic [3:0] byteSelect;
  logic [19:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic busy;
  modport master(output writeEnable, readEnable, byteSelect, address, writeData, input readData, busy);
  modport slave(input writeEnable, readEnable, byteSelect, address, writeData, output readData, busy);
endinterface

// File: rtl/management_timeout_counter.sv
// management_timeout_counter: counts stalled access cycles, flags the last tolerated one
module management_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic countEnable,
  output logic terminalCount
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (countEnable) count <= count + 1'b1;
  assign terminalCount = count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/management_bus_arbiter.sv
// management_bus_arbiter: round-robin JTAG/Wishbone sequencer for the core management bus;
// bus timeout abort is built only with MANAGEMENT_ARBITER_TIMEOUT_EN.
module management_bus_arbiter
  import management_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  management_bus_arbiter_if.slave jtag,
  management_bus_arbiter_if.slave wb,
  management_bus_arbiter_if.master bus,
  input  logic timeout_clear,
  output logic timeout_error
);
  arbState_e state, nextState;
  logic grant, lastGrant, pick, reqJtag, reqWb, abort;
  logic [31:0] respData;
  assign reqJtag = jtag.writeEnable | jtag.readEnable;
  assign reqWb = wb.writeEnable | wb.readEnable;
  assign pick = (reqJtag && reqWb) ? ~lastGrant : (reqJtag ? MASTER_JTAG : MASTER_WB);
  always_comb begin
    nextState = state;
    if (state == IDLE) nextState = (reqJtag || reqWb) ? ACCESS : IDLE;
    else if (state == ACCESS) nextState = (!bus.busy || abort) ? RESPOND : ACCESS;
    else nextState = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  // bus_* hold the granted request only while in ACCESS; a write returns zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= MASTER_JTAG;
      lastGrant <= MASTER_WB;
      respData <= '0;
      bus.writeEnable <= 1'b0;
      bus.readEnable <= 1'b0;
      bus.byteSelect <= '0;
      bus.address <= '0;
      bus.writeData <= '0;
    end else if (state == IDLE && nextState == ACCESS) begin
      grant <= pick;
      lastGrant <= pick;
      bus.writeEnable <= (pick == MASTER_WB) ? wb.writeEnable : jtag.writeEnable;
      bus.readEnable <= (pick == MASTER_WB) ? wb.readEnable & ~wb.writeEnable : jtag.readEnable & ~jtag.writeEnable;
      bus.byteSelect <= (pick == MASTER_WB) ? wb.byteSelect : jtag.byteSelect;
      bus.address <= (pick == MASTER_WB) ? wb.address : jtag.address;
      bus.writeData <= (pick == MASTER_WB) ? wb.writeData : jtag.writeData;
    end else if (state == ACCESS && nextState == RESPOND) begin
      respData <= abort ? ABORT_DATA : (bus.writeEnable ? '0 : bus.readData);
      bus.writeEnable <= 1'b0;
      bus.readEnable <= 1'b0;
      bus.byteSelect <= '0;
      bus.address <= '0;
      bus.writeData <= '0;
    end
  end
  assign jtag.readData = (state == RESPOND && grant == MASTER_JTAG) ? respData : '0;
  assign wb.readData = (state == RESPOND && grant == MASTER_WB) ? respData : '0;
  assign jtag.busy = reqJtag & ~(state == RESPOND && grant == MASTER_JTAG);
  assign wb.busy = reqWb & ~(state == RESPOND && grant == MASTER_WB);
`ifdef MANAGEMENT_ARBITER_TIMEOUT_EN
  logic terminalCount;
  management_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) timeoutCounter (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state != ACCESS),
    .countEnable(state == ACCESS && bus.busy),
    .terminalCount(terminalCount)
  );
  assign abort = state == ACCESS && bus.busy && terminalCount;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timeout_error <= 1'b0;
    else timeout_error <= timeout_clear ? 1'b0 : (abort ? 1'b1 : timeout_error);
`else
  localparam int unusedTimeout = TIMEOUT_CYCLES;
  logic unusedClear;
  assign unusedClear = timeout_clear;
  assign abort = 1'b0;
  assign timeout_error = 1'b0;
`endif
endmodule

// File: tb/tb_management_bus_arbiter.sv
// tb_management_bus_arbiter: scoreboard bench for the JTAG/Wishbone management arbiter
module tb_management_bus_arbiter;
  import management_bus_arbiter_pkg::*;
  typedef struct {logic m; logic [31:0] data; int at;} resp_t;
  typedef struct {logic we; logic re; logic [3:0] be; logic [19:0] addr; logic [31:0] wd; int at; int len;} busTxn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_clear = 1'b0;
  logic timeout_error;
  logic [31:0] rdData = '0;
  int stall = 0;
  int accCnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  resp_t respQ[$];
  busTxn_t busQ[$];
  management_bus_arbiter_if jtagIf();
  management_bus_arbiter_if wbIf();
  management_bus_arbiter_if busIf();
  management_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .jtag(jtagIf),
    .wb(wbIf),
    .bus(busIf),
    .timeout_clear(timeout_clear),
    .timeout_error(timeout_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // downstream model: stalls the first `stall` cycles of every access
  always @(posedge clk) accCnt <= (busIf.writeEnable | busIf.readEnable) ? accCnt + 1 : 0;
  assign busIf.busy = (busIf.writeEnable | busIf.readEnable) && accCnt < stall;
  assign busIf.readData = rdData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monResp(input logic m, input logic req, input logic busy, input logic [31:0] rd);
    resp_t e;
    if (req && !busy) begin
      if (respQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected completion: master %0d completed, expected none (cycle %0d)", m, cyc);
      end else begin
        e = respQ.pop_front();
        check("grant order", 32'(m), 32'(e.m));
        check("readData", rd, e.data);
        check("completion cycle", cyc, e.at);
      end
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    monResp(MASTER_JTAG, jtagIf.writeEnable | jtagIf.readEnable, jtagIf.busy, jtagIf.readData);
    monResp(MASTER_WB, wbIf.writeEnable | wbIf.readEnable, wbIf.busy, wbIf.readData);
  end

  logic prevStrobe = 1'b0;
  int strobeLen = 0;
  busTxn_t cur;
  always @(negedge clk) begin
    if (busIf.writeEnable | busIf.readEnable) begin
      if (!prevStrobe) begin
        strobeLen = 1;
        if (busQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected bus access: addr 0x%05h, expected none (cycle %0d)", busIf.address, cyc);
        end else begin
          cur = busQ.pop_front();
          check("bus writeEnable", 32'(busIf.writeEnable), 32'(cur.we));
          check("bus readEnable", 32'(busIf.readEnable), 32'(cur.re));
          check("bus byteSelect", 32'(busIf.byteSelect), 32'(cur.be));
          check("bus address", 32'(busIf.address), 32'(cur.addr));
          check("bus writeData", busIf.writeData, cur.wd);
          check("bus start cycle", cyc, cur.at);
        end
      end else strobeLen++;
    end else if (prevStrobe) check("bus strobe length", strobeLen, cur.len);
    prevStrobe = busIf.writeEnable | busIf.readEnable;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic m, input logic we, input logic re, input logic [19:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (m == MASTER_JTAG) begin
      jtagIf.writeEnable = we; jtagIf.readEnable = re; jtagIf.address = a; jtagIf.byteSelect = be; jtagIf.writeData = wd;
    end else begin
      wbIf.writeEnable = we; wbIf.readEnable = re; wbIf.address = a; wbIf.byteSelect = be; wbIf.writeData = wd;
    end
  endtask

  task automatic expResp(input logic m, input logic [31:0] d, input int at);
    respQ.push_back('{m, d, at});
  endtask

  task automatic expBus(input logic we, input logic re, input logic [3:0] be, input logic [19:0] a, input logic [31:0] wd, input int at, input int len);
    busQ.push_back('{we, re, be, a, wd, at, len});
  endtask

  task automatic waitDone(input logic m, input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!(m == MASTER_JTAG ? jtagIf.busy : wbIf.busy)) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s completion wait: still busy after %0d cycles, expected done", m == MASTER_JTAG ? "jtag" : "wb", bound);
    end
    tick();
    drive(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    int c;
    drive(MASTER_JTAG, 1'b0, 1'b0, '0, '0, '0);
    drive(MASTER_WB, 1'b0, 1'b0, '0, '0, '0);
    tick(2);
    check("reset bus writeEnable", 32'(busIf.writeEnable), 0);
    check("reset bus readEnable", 32'(busIf.readEnable), 0);
    check("reset bus address", 32'(busIf.address), 0);
    check("reset timeout_error", 32'(timeout_error), 0);
    drive(MASTER_WB, 1'b0, 1'b1, 20'h00001, 4'hF, '0);
    #1;
    check("reset wb busy follows request", 32'(wbIf.busy), 1);
    check("reset wb readData", wbIf.readData, 0);
    drive(MASTER_WB, 1'b0, 1'b0, '0, '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    // first tie after reset goes to JTAG
    c = cyc; rdData = 32'h0000_1111;
    drive(MASTER_JTAG, 1'b0, 1'b1, 20'h00100, 4'h3, '0);
    drive(MASTER_WB, 1'b1, 1'b0, 20'h00200, 4'hC, 32'hA5A5_0001);
    expBus(1'b0, 1'b1, 4'h3, 20'h00100, '0, c + 1, 1);
    expBus(1'b1, 1'b0, 4'hC, 20'h00200, 32'hA5A5_0001, c + 4, 1);
    expResp(MASTER_JTAG, 32'h0000_1111, c + 2);
    expResp(MASTER_WB, 32'h0, c + 5);
    fork waitDone(MASTER_JTAG, 10); waitDone(MASTER_WB, 10); join
    // single JTAG read at minimum latency
    tick();
    c = cyc; rdData = 32'h12;
    drive(MASTER_JTAG, 1'b0, 1'b1, 20'h00004, 4'hF, '0);
    expBus(1'b0, 1'b1, 4'hF, 20'h00004, '0, c + 1, 1);
    expResp(MASTER_JTAG, 32'h12, c + 2);
    fork
      waitDone(MASTER_JTAG, 10);
      begin repeat (3) begin @(negedge clk); check("wb busy while jtag served", 32'(wbIf.busy), 0); end end
    join
    // JTAG was last served, so this tie goes to WB; JTAG with both enables is a write
    c = cyc; rdData = 32'hCAFE_F00D;
    drive(MASTER_WB, 1'b0, 1'b1, 20'h00300, 4'hF, '0);
    drive(MASTER_JTAG, 1'b1, 1'b1, 20'h00400, 4'h1, 32'h1234_5678);
    expBus(1'b0, 1'b1, 4'hF, 20'h00300, '0, c + 1, 1);
    expBus(1'b1, 1'b0, 4'h1, 20'h00400, 32'h1234_5678, c + 4, 1);
    expResp(MASTER_WB, 32'hCAFE_F00D, c + 2);
    expResp(MASTER_JTAG, 32'h0, c + 5);
    fork waitDone(MASTER_JTAG, 10); waitDone(MASTER_WB, 10); join
    // WB write stalled three cycles
    tick();
    c = cyc; stall = 3; rdData = 32'h5555_5555;
    drive(MASTER_WB, 1'b1, 1'b0, 20'h10000, 4'hF, 32'hDEAD_BEEF);
    expBus(1'b1, 1'b0, 4'hF, 20'h10000, 32'hDEAD_BEEF, c + 1, 4);
    expResp(MASTER_WB, 32'h0, c + 5);
    waitDone(MASTER_WB, 12);
    // downstream stuck busy
    tick();
    c = cyc; stall = 1000; rdData = 32'h77;
    drive(MASTER_JTAG, 1'b0, 1'b1, 20'h00008, 4'h2, '0);
`ifdef MANAGEMENT_ARBITER_TIMEOUT_EN
    expBus(1'b0, 1'b1, 4'h2, 20'h00008, '0, c + 1, 8);
    expResp(MASTER_JTAG, ABORT_DATA, c + 9);
    waitDone(MASTER_JTAG, 20);
    check("timeout_error set", 32'(timeout_error), 1);
    tick(3);
    check("timeout_error sticky", 32'(timeout_error), 1);
    timeout_clear = 1'b1;
    tick();
    timeout_clear = 1'b0;
    check("timeout_error cleared", 32'(timeout_error), 0);
`else
    expBus(1'b0, 1'b1, 4'h2, 20'h00008, '0, c + 1, 12);
    expResp(MASTER_JTAG, 32'h77, c + 13);
    tick(12);
    check("stalled jtag busy", 32'(jtagIf.busy), 1);
    check("stalled bus readEnable", 32'(busIf.readEnable), 1);
    check("no timeout_error", 32'(timeout_error), 0);
    stall = 0;
    timeout_clear = 1'b1;
    waitDone(MASTER_JTAG, 5);
    timeout_clear = 1'b0;
    check("timeout_error stays low", 32'(timeout_error), 0);
`endif
    stall = 0;
    // reset during ACCESS, held request re-arbitrated afterwards
    tick();
    c = cyc; stall = 1000; rdData = 32'h99;
    drive(MASTER_JTAG, 1'b0, 1'b1, 20'h0000C, 4'h8, '0);
    expBus(1'b0, 1'b1, 4'h8, 20'h0000C, '0, c + 1, 1);
    expBus(1'b0, 1'b1, 4'h8, 20'h0000C, '0, c + 4, 1);
    expResp(MASTER_JTAG, 32'h99, c + 5);
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    check("reset drops readEnable", 32'(busIf.readEnable), 0);
    check("reset keeps jtag busy", 32'(jtagIf.busy), 1);
    stall = 0;
    tick();
    rst_n = 1'b1;
    waitDone(MASTER_JTAG, 10);
    // WB drops mid-ACCESS, pending JTAG served next
    tick();
    c = cyc; stall = 2; rdData = 32'h42;
    drive(MASTER_WB, 1'b0, 1'b1, 20'h00500, 4'hF, '0);
    expBus(1'b0, 1'b1, 4'hF, 20'h00500, '0, c + 1, 3);
    tick();
    drive(MASTER_WB, 1'b0, 1'b0, '0, '0, '0);
    drive(MASTER_JTAG, 1'b0, 1'b1, 20'h00600, 4'h4, '0);
    expBus(1'b0, 1'b1, 4'h4, 20'h00600, '0, c + 6, 3);
    expResp(MASTER_JTAG, 32'h42, c + 9);
    tick(3);
    @(negedge clk);
    check("dropped wb busy in RESPOND", 32'(wbIf.busy), 0);
    check("dropped wb readData in RESPOND", wbIf.readData, 32'h42);
    check("pending jtag busy", 32'(jtagIf.busy), 1);
    waitDone(MASTER_JTAG, 10);
    tick(2);
    check("response queue drained", respQ.size(), 0);
    check("bus queue drained", busQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/management_bus_arbiter.md
# management_bus_arbiter

Registered arbiter and transaction sequencer that shares the core management bus between the JTAG and Wishbone management masters. It replaces combinational master priority with round-robin arbitration, a per-transaction state machine, a downstream stall handshake and an optional bus timeout. It sits between the two management master interfaces and the core management register/memory decode.

## Interface
- TIMEOUT_CYCLES, 256: downstream busy cycles tolerated before a transaction is aborted; used only when timeout is compiled in.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- jtag_writeEnable / jtag_readEnable  in  1 each  JTAG request; held until the cycle `jtag_busy` is low.
- jtag_byteSelect  in  4; jtag_address  in  20; jtag_writeData  in  32: JTAG request fields, stable while the request is held.
- jtag_readData  out  32  read result; valid only in the completion cycle.
- jtag_busy  out  1  high while a JTAG request is pending; low marks completion.
- wb_*  (same seven ports as jtag_*)  Wishbone management master.
- bus_writeEnable / bus_readEnable  out  1 each  downstream strobes, registered.
- bus_byteSelect  out  4; bus_address  out  20; bus_writeData  out  32: registered downstream fields.
- bus_readData  in  32; bus_busy  in  1  downstream stall.
- timeout_error  out  1  sticky abort flag.
- timeout_clear  in  1  clears `timeout_error`.

## Operation
- request_m = m_writeEnable | m_readEnable. If both enables are high, the transaction is a write.
- State machine:
  - IDLE: any request goes to ACCESS with that master granted.
  - ACCESS: stays while `bus_busy` is high. Goes to RESPOND when `bus_busy` is low.
  - RESPOND: always returns to IDLE.
- Arbitration happens only in IDLE.
  - One requester: grant it.
  - Both requesting: grant the master that is not `lastGrant`.
  - `lastGrant` updates on every grant. It resets to WB, so JTAG wins the first tie.
- On the IDLE→ACCESS edge, latch the granted master's address, byteSelect, writeData and direction into the bus_* registers.
  - Strobes stay asserted for all of ACCESS.
  - All bus_* outputs are 0 outside ACCESS.
- On the ACCESS→RESPOND edge, register `bus_readData` into `respData`. For a write, `respData` is 0.
- m_readData = `respData` when in RESPOND and m is granted; otherwise 0.
- m_busy = request_m & ~(state==RESPOND & grant==m). This is combinational, so busy is high in the very cycle the request first appears.
- Requester drops its request during ACCESS: the downstream transaction still completes, RESPOND still occurs, and the result is discarded. No abort toward the bus.
- A new request from the just-served master in RESPOND is not taken until the following IDLE cycle.

## Timing
- Reset values:
  - State IDLE, `lastGrant` WB.
  - All bus_* outputs 0, `respData` 0, `timeout_error` 0.
  - Therefore both m_readData are 0, and m_busy follows request_m only.
- Reset asserted mid-transaction: immediate return to IDLE. Downstream strobes drop asynchronously. The pending master sees busy held high and its request is re-arbitrated after reset.
- Minimum latency with `bus_busy` low:
  - Request in IDLE at cycle 0.
  - ACCESS with strobes at cycle 1.
  - RESPOND at cycle 2: busy low, data valid.
  - Busy is high for exactly 2 cycles.
- Each downstream busy cycle adds one cycle of latency.
- Losing requester: busy stays high through the winner's full transaction. It is granted in the IDLE cycle after the winner's RESPOND.

## Configuration
- MANAGEMENT_ARBITER_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with `bus_busy` high.
  - When it reaches TIMEOUT_CYCLES-1 with `bus_busy` still high, go to RESPOND with `respData` = 32'hFFFF_FFFF and set `timeout_error`.
  - `timeout_clear` has priority; setting and clearing in the same cycle leaves the flag cleared.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - `timeout_error` is tied 0 and `timeout_clear` is ignored.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2);
  - master index constants (MASTER_JTAG=1'b0, MASTER_WB=1'b1);
  - the fixed abort data value 32'hFFFF_FFFF.
- One sub-module, management_timeout_counter: clear, count-enable, terminal-count output, width $clog2(TIMEOUT_CYCLES). Instantiated only under MANAGEMENT_ARBITER_TIMEOUT_EN.

## Test plan
- JTAG read of 0x00004 with `bus_busy` low and `bus_readData`=0x12 → strobes in cycle 1, `jtag_readData`=0x12 with `jtag_busy` low in cycle 2, `wb_busy` 0 throughout.
- JTAG and WB requests in the same cycle after reset → JTAG granted first, WB granted in the cycle after JTAG's RESPOND. Repeated simultaneous requests alternate WB, JTAG.
- WB write 0x10000 / 0xDEADBEEF / byteSelect 4'hF with `bus_busy` high for 3 cycles → `bus_writeEnable` held 4 cycles, `wb_busy` low in cycle 5, `wb_readData`=0.
- Timeout build with TIMEOUT_CYCLES=8 and `bus_busy` stuck high → abort after 8 ACCESS cycles, `readData`=0xFFFFFFFF, `timeout_error`=1 until `timeout_clear` is pulsed.
- Reset asserted during ACCESS → strobes 0 immediately. After release, the held request re-enters ACCESS one cycle later.
- WB request dropped mid-ACCESS → transaction completes, RESPOND with `wb_busy`=0, then IDLE. A pending JTAG request is granted next.
